// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control and the downstream ALU control stage.
// Define JUMP_INSTR_EN to enable the J instruction (JUMP state and the jump-target PC source).
package mc_ctrl_pkg;

    localparam int ST_W = 4;
    typedef logic [ST_W-1:0] state_t;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_EXECUTE  = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
`ifdef JUMP_INSTR_EN
    localparam logic [3:0] ST_JUMP     = 4'd9;
`endif

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef JUMP_INSTR_EN
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic opcode_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef JUMP_INSTR_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decoder; zero latency, no backpressure of its own.
// Only FETCH looks at mem_ready (IR/PC load qualified by memory completion); JUMP decode under JUMP_INSTR_EN.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
`ifdef JUMP_INSTR_EN
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control FSM: state register, run flag, latched opcode, next-state logic.
// Latency FETCH-to-FETCH without stalls: LW 5, SW 4, R 4, BEQ 3, J 3 (J only with JUMP_INSTR_EN).
// Backpressure: FETCH, MEM_RD and MEM_WR hold until MEM_READY; every other state lasts one cycle.
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = ST_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [5:0]         OPCODE,
    input  logic               MEM_READY,
    output logic               PC_WRITE,
    output logic               PC_WRITE_COND,
    output logic               I_OR_D,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic               IR_WRITE,
    output logic               MEM_TO_REG,
    output logic               REG_DST,
    output logic               REG_WRITE,
    output logic               ALU_SRC_A,
    output logic [1:0]         ALU_SRC_B,
    output logic [1:0]         ALU_OP,
    output logic [1:0]         PC_SOURCE,
    output logic               ILLEGAL,
    output logic [STATE_W-1:0] STATE
);

    state_t     state;
    state_t     state_nxt;
    logic       run;
    logic [5:0] opcode_q;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_FETCH;
            run      <= 1'b0;
            opcode_q <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                state <= state_nxt;
                if (state == ST_DECODE) begin
                    opcode_q <= OPCODE;
                end
            end
        end
    end

    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_FETCH:    state_nxt = MEM_READY ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
                    OP_R:         state_nxt = ST_EXECUTE;
                    OP_BEQ:       state_nxt = ST_BRANCH;
`ifdef JUMP_INSTR_EN
                    OP_J:         state_nxt = ST_JUMP;
`endif
                    default:      state_nxt = ST_FETCH;
                endcase
            end
            // Only LW/SW can reach MEM_ADDR, so the latched copy picks between them.
            ST_MEM_ADDR: state_nxt = (opcode_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_nxt = MEM_READY ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_nxt = ST_FETCH;
            ST_MEM_WR:   state_nxt = MEM_READY ? ST_FETCH : ST_MEM_WR;
            ST_EXECUTE:  state_nxt = ST_R_WB;
            ST_R_WB:     state_nxt = ST_FETCH;
            ST_BRANCH:   state_nxt = ST_FETCH;
`ifdef JUMP_INSTR_EN
            ST_JUMP:     state_nxt = ST_FETCH;
`endif
            default:     state_nxt = ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (MEM_READY),
        .ctrl      (ctrl)
    );

    // run clears asynchronously with reset, so gating on it also blanks outputs immediately.
    assign ctrl_out      = run ? ctrl : '0;
    assign PC_WRITE      = ctrl_out.pc_write;
    assign PC_WRITE_COND = ctrl_out.pc_write_cond;
    assign I_OR_D        = ctrl_out.i_or_d;
    assign MEM_READ      = ctrl_out.mem_read;
    assign MEM_WRITE     = ctrl_out.mem_write;
    assign IR_WRITE      = ctrl_out.ir_write;
    assign MEM_TO_REG    = ctrl_out.mem_to_reg;
    assign REG_DST       = ctrl_out.reg_dst;
    assign REG_WRITE     = ctrl_out.reg_write;
    assign ALU_SRC_A     = ctrl_out.alu_src_a;
    assign ALU_SRC_B     = ctrl_out.alu_src_b;
    assign ALU_OP        = ctrl_out.alu_op;
    assign PC_SOURCE     = ctrl_out.pc_source;
    assign ILLEGAL       = run && (state == ST_DECODE) && !opcode_supported(OPCODE);
    assign STATE         = run ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench: instruction-level model pushes per-cycle expected outputs, negedge monitor compares.
module tb_multicycle_main_control;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [5:0] OPCODE = '0;
    logic       MEM_READY = 1'b0;
    logic       PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE;
    logic       MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ILLEGAL;
    logic [1:0] ALU_SRC_B, ALU_OP, PC_SOURCE;
    logic [3:0] STATE;

`ifdef JUMP_INSTR_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, J_OP = 6'b000010, BAD_OP = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic ill;
    } obs_t;

    obs_t exp_q[$];
    obs_t act;
    int   checks = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    multicycle_main_control dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND), .I_OR_D(I_OR_D),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
        .MEM_TO_REG(MEM_TO_REG), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
        .PC_SOURCE(PC_SOURCE), .ILLEGAL(ILLEGAL), .STATE(STATE)
    );

    assign act = {STATE, PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE,
                  MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SOURCE, ILLEGAL};

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle_check t=%0t exp_state=%0d: got %h required %h", $time, e.st, act, e);
            end
        end
    end

    // Expected outputs of one cycle spent in the named state.
    function automatic obs_t mk(input int st, input bit rdy, input bit ill);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0: begin o.mrd = 1; o.srcb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            1: begin o.srcb = 2'b11; o.ill = ill; end
            2: begin o.srca = 1; o.srcb = 2'b10; end
            3: begin o.mrd = 1; o.iord = 1; end
            4: begin o.rw = 1; o.m2r = 1; end
            5: begin o.mwr = 1; o.iord = 1; end
            6: begin o.srca = 1; o.aluop = 2'b10; end
            7: begin o.rw = 1; o.rdst = 1; end
            8: begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
            9: begin o.pcw = 1; o.pcsrc = 2'b10; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == R_OP || op == LW_OP || op == SW_OP || op == BEQ_OP || (op == J_OP && JUMP_EN);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic step(input logic [5:0] op, input logic rdy, input obs_t e);
        OPCODE = op;
        MEM_READY = rdy;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Fetch + decode of one instruction; returns whether execution continues.
    task automatic front(input logic [5:0] op, input int fstall, output bit go);
        logic r;
        for (int i = 0; i < fstall; i++) step(rop(), 1'b0, mk(0, 0, 0));
        step(rop(), 1'b1, mk(0, 1, 0));
        r = rb();
        go = legal(op);
        step(op, r, mk(1, r, !go));
    endtask

    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        bit go;
        int mst;
        front(op, fstall, go);
        if (go) begin
            if (op == LW_OP || op == SW_OP) begin
                mst = (op == LW_OP) ? 3 : 5;
                step(rop(), rb(), mk(2, 0, 0));
                for (int i = 0; i < mstall; i++) step(rop(), 1'b0, mk(mst, 0, 0));
                step(rop(), 1'b1, mk(mst, 0, 0));
                if (op == LW_OP) step(rop(), rb(), mk(4, 0, 0));
            end else if (op == R_OP) begin
                step(rop(), rb(), mk(6, 0, 0));
                step(rop(), rb(), mk(7, 0, 0));
            end else if (op == BEQ_OP) begin
                step(rop(), rb(), mk(8, 0, 0));
            end else begin
                step(rop(), rb(), mk(9, 0, 0));
            end
        end
    endtask

    task automatic reset_cycles(input int n);
        RST_N = 1'b0;
        for (int i = 0; i < n; i++) step(rop(), rb(), '0);
        RST_N = 1'b1;
        step(rop(), rb(), '0);  // run flag still clear until the first edge
    endtask

    initial begin
        logic [5:0] ops [7];
        bit go;
        ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, BAD_OP, 6'b0};
        @(posedge CLK);
        #1;
        reset_cycles(3);

        run_instr(LW_OP, 0, 0);
        run_instr(SW_OP, 0, 3);
        run_instr(R_OP, 1, 0);
        run_instr(BEQ_OP, 0, 0);
        run_instr(BAD_OP, 0, 0);
        run_instr(J_OP, 0, 0);
        run_instr(LW_OP, 2, 2);

        // Abort mid-load: reset lands asynchronously while parked in MEM_RD.
        front(LW_OP, 0, go);
        step(rop(), rb(), mk(2, 0, 0));
        step(rop(), 1'b0, mk(3, 0, 0));
        RST_N = 1'b0;
        step(rop(), rb(), '0);
        reset_cycles(1);
        run_instr(SW_OP, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b0 && $urandom_range(0, 1) == 1) op = rop();
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
